mul_seq_shift_add: RTL and testbench
====================================

# mul_seq_shift_add

Parametrised sequential shift-add multiplier: the clocked, width-generic successor to the team's flat 8-bit combinational truncating multiplier netlists. It accepts one operand pair through a valid/ready handshake and iterates one multiplier bit per clock. It returns either the truncated low word or the full double-width product, with a truncation-overflow flag and selectable signed/unsigned mode. It sits in the benchmark datapath as a low-area alternative wherever a fixed multi-cycle latency is acceptable.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- FULL_PRODUCT, 0, 0 = product is low WIDTH bits (truncated, like the 8-bit netlist); 1 = product is 2*WIDTH bits.
- OUT_W (derived, not overridable), FULL_PRODUCT ? 2*WIDTH : WIDTH.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- signed_mode  in  1  1 = a, b are two's complement; sampled with the operands.
- out_valid  out  1  result available; high only in DONE.
- out_ready  in  1  consumer takes result.
- product  out  OUT_W  result, registered.
- trunc_ovf  out  1  1 = discarded upper bits were significant (always 0 when FULL_PRODUCT=1).

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state IDLE.
- IDLE: in_ready=1. On in_valid: capture |a| and |b| (magnitudes when signed_mode=1, raw otherwise). Also capture the result sign neg = signed_mode & (a[W-1]^b[W-1]). Clear the 2*WIDTH accumulator and the bit counter, then go to BUSY.
- BUSY: each cycle, if the current multiplier LSB is 1, add the multiplicand into the accumulator upper half with carry. Then shift the accumulator and the multiplier right by 1 and increment the counter. After exactly WIDTH BUSY cycles, go to DONE.
- On the transition into DONE, register the final value: the full product P = neg ? -acc : acc (2*WIDTH two's complement). product = P[OUT_W-1:0].
- Magnitude of the most negative value (e.g. -128 for WIDTH=8) is 2^(W-1); this fits the unsigned WIDTH-bit magnitude register with no special case.
- trunc_ovf (FULL_PRODUCT=0 only):
  - unsigned mode: P[2W-1:W] != 0.
  - signed mode: P[2W-1:W-1] is not all-zeros and not all-ones.
- DONE: out_valid=1. product and trunc_ovf are held stable until out_ready. When out_ready=1: go to IDLE, and out_valid drops on that edge.
- in_valid outside IDLE is ignored; operands are not queued.
- Latency is fixed regardless of operand values; zero operands still take WIDTH BUSY cycles.
- Asynchronous reset at any time, including mid-BUSY or in DONE: immediately go to IDLE and clear accumulator, counter, product, trunc_ovf and out_valid. The in-flight operation is discarded with no output.
- Arithmetic is modulo 2^(2*WIDTH) internally; no saturation.

## Timing
- Reset values: in_ready=1, out_valid=0, product=0, trunc_ovf=0.
- Handshake accepted at rising edge E0 (in_valid & in_ready). in_ready is low from after E0.
- out_valid rises after edge E0+WIDTH+... precisely: BUSY occupies edges E1..EWIDTH, and out_valid=1 and product valid immediately after edge EWIDTH.
- Result consumed at the first edge in DONE where out_ready=1. in_ready returns high after that edge. A new operand can be accepted at the following edge.
- Throughput: one result per WIDTH+2 cycles when out_ready is held high.
- out_ready already high on entry to DONE: out_valid is high for exactly one cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, FULL=0, unsigned: a=0xFF, b=0xFF -> product=0x01, trunc_ovf=1, out_valid exactly 8 edges after accept.
- WIDTH=8, FULL=1, unsigned: a=0xFF, b=0xFF -> product=0xFE01, trunc_ovf=0; a=15, b=17 -> 0x00FF.
- WIDTH=8, FULL=0, signed: a=0xFF(-1), b=0xFF -> 0x01, ovf=0; a=64, b=2 -> 0x80, ovf=1; a=0x80, b=0x80 -> 0x00, ovf=1; a=0xF0(-16), b=4 -> 0xC0, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> product stable and in_ready=0 throughout. Toggling in_valid with new operands during BUSY/DONE -> result unchanged, nothing accepted.
- Reset mid-operation: assert rst_n=0 asynchronously at BUSY cycle 3 -> outputs 0 at once, no out_valid afterwards. The next transaction 3*5 -> 15 is correct.
- Random sweep, WIDTH=4 and WIDTH=16, both modes, both FULL_PRODUCT settings, with back-to-back transactions -> product and trunc_ovf match the reference model. With out_ready tied high, spacing is WIDTH+2 cycles.

Source files
------------

// File: rtl/mul_seq_shift_add_if.sv
// Operand/result handshake bundle for the sequential shift-add multiplier.
// Latency: none, this is wiring only.
// Backpressure: valid/ready on both the operand side and the result side.
//
// Ports carried:
//   in_valid / in_ready : operand pair handshake (a, b, signed_mode)
//   out_valid / out_ready : result handshake (product, trunc_ovf)
// master = producer of operands / consumer of results, slave = the multiplier.
interface mul_seq_shift_add_if #(
    parameter int WIDTH        = 8,
    parameter int FULL_PRODUCT = 0
);
    localparam int OUT_W = (FULL_PRODUCT != 0) ? 2 * WIDTH : WIDTH;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] product;
    logic             trunc_ovf;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, product, trunc_ovf
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, product, trunc_ovf
    );
endinterface

// File: rtl/mul_seq_shift_add.sv
// Sequential shift-add multiplier, one multiplier bit per clock, signed or unsigned.
// Latency: result valid WIDTH cycles after the operand handshake; WIDTH+2 cycles per result.
// Backpressure: result held in DONE until out_ready; operands refused (in_ready=0) outside IDLE.
//
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : slave side of mul_seq_shift_add_if (operands in, product/trunc_ovf out)
module mul_seq_shift_add #(
    parameter int WIDTH        = 8,
    parameter int FULL_PRODUCT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    mul_seq_shift_add_if.slave bus
);
    localparam int OUT_W = (FULL_PRODUCT != 0) ? 2 * WIDTH : WIDTH;
    localparam int CW    = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               neg;
    logic               sgn;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [OUT_W-1:0]   product_q;
    logic               trunc_ovf_q;

    // Operand magnitudes. The most negative value negates to itself, which
    // read as unsigned is exactly 2^(WIDTH-1), so no special case is needed.
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    assign a_mag = (bus.signed_mode && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
    assign b_mag = (bus.signed_mode && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;

    // One iteration: conditional add into the upper half (carry kept in the
    // extra sum bit), then the whole accumulator shifts right by one.
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_shf;
    assign sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
    assign acc_shf = {sum, acc[WIDTH-1:1]};

    // Final signed/unsigned product, valid on the last BUSY iteration.
    logic [2*WIDTH-1:0] p_full;
    logic [WIDTH-1:0]   hi_u;
    logic [WIDTH:0]     hi_s;
    logic               ovf_next;
    assign p_full = neg ? (~acc_shf + (2*WIDTH)'(1)) : acc_shf;
    assign hi_u   = p_full[2*WIDTH-1:WIDTH];
    // Signed truncation is lossless only if the discarded bits plus the new
    // sign bit are a pure sign extension.
    assign hi_s   = p_full[2*WIDTH-1:WIDTH-1];
    assign ovf_next = (FULL_PRODUCT == 0) &&
                      (sgn ? !((&hi_s) || (~|hi_s)) : (|hi_u));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            cnt         <= '0;
            neg         <= 1'b0;
            sgn         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            product_q   <= '0;
            trunc_ovf_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand      <= a_mag;
                        mplier     <= b_mag;
                        neg        <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        sgn        <= bus.signed_mode;
                        acc        <= '0;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    acc    <= acc_shf;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        product_q   <= p_full[OUT_W-1:0];
                        trunc_ovf_q <= ovf_next;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;
    assign bus.trunc_ovf = trunc_ovf_q;
endmodule

// File: tb/tb_mul_seq_shift_add.sv
// Bench for mul_seq_shift_add: three widths (8, 4, 16), each with a truncating
// and a full-product instance sharing stimulus. grp selects the active pair.
module tb_mul_seq_shift_add;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        sm = 1'b0;
    logic [31:0] a_drv = '0;
    logic [31:0] b_drv = '0;
    int          grp = 0;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mul_seq_shift_add_if #(.WIDTH(8),  .FULL_PRODUCT(0)) i8t ();
    mul_seq_shift_add_if #(.WIDTH(8),  .FULL_PRODUCT(1)) i8f ();
    mul_seq_shift_add_if #(.WIDTH(4),  .FULL_PRODUCT(0)) i4t ();
    mul_seq_shift_add_if #(.WIDTH(4),  .FULL_PRODUCT(1)) i4f ();
    mul_seq_shift_add_if #(.WIDTH(16), .FULL_PRODUCT(0)) i16t ();
    mul_seq_shift_add_if #(.WIDTH(16), .FULL_PRODUCT(1)) i16f ();

    assign i8t.in_valid  = in_valid && (grp == 0); assign i8f.in_valid  = in_valid && (grp == 0);
    assign i4t.in_valid  = in_valid && (grp == 1); assign i4f.in_valid  = in_valid && (grp == 1);
    assign i16t.in_valid = in_valid && (grp == 2); assign i16f.in_valid = in_valid && (grp == 2);
    assign i8t.a  = a_drv[7:0];  assign i8t.b  = b_drv[7:0];  assign i8f.a  = a_drv[7:0];  assign i8f.b  = b_drv[7:0];
    assign i4t.a  = a_drv[3:0];  assign i4t.b  = b_drv[3:0];  assign i4f.a  = a_drv[3:0];  assign i4f.b  = b_drv[3:0];
    assign i16t.a = a_drv[15:0]; assign i16t.b = b_drv[15:0]; assign i16f.a = a_drv[15:0]; assign i16f.b = b_drv[15:0];
    assign i8t.signed_mode = sm; assign i8f.signed_mode = sm; assign i4t.signed_mode = sm;
    assign i4f.signed_mode = sm; assign i16t.signed_mode = sm; assign i16f.signed_mode = sm;
    assign i8t.out_ready = out_ready; assign i8f.out_ready = out_ready; assign i4t.out_ready = out_ready;
    assign i4f.out_ready = out_ready; assign i16t.out_ready = out_ready; assign i16f.out_ready = out_ready;

    mul_seq_shift_add #(.WIDTH(8),  .FULL_PRODUCT(0)) u8t  (.clk(clk), .rst_n(rst_n), .bus(i8t));
    mul_seq_shift_add #(.WIDTH(8),  .FULL_PRODUCT(1)) u8f  (.clk(clk), .rst_n(rst_n), .bus(i8f));
    mul_seq_shift_add #(.WIDTH(4),  .FULL_PRODUCT(0)) u4t  (.clk(clk), .rst_n(rst_n), .bus(i4t));
    mul_seq_shift_add #(.WIDTH(4),  .FULL_PRODUCT(1)) u4f  (.clk(clk), .rst_n(rst_n), .bus(i4f));
    mul_seq_shift_add #(.WIDTH(16), .FULL_PRODUCT(0)) u16t (.clk(clk), .rst_n(rst_n), .bus(i16t));
    mul_seq_shift_add #(.WIDTH(16), .FULL_PRODUCT(1)) u16f (.clk(clk), .rst_n(rst_n), .bus(i16f));

    logic        cur_rdy, cur_vld, cur_vld_f, cur_ot, cur_of;
    logic [63:0] cur_pt, cur_pf;

    always_comb begin
        cur_rdy = 1'b0; cur_vld = 1'b0; cur_vld_f = 1'b0; cur_ot = 1'b0; cur_of = 1'b0;
        cur_pt = '0; cur_pf = '0;
        case (grp)
            0: begin
                cur_rdy = i8t.in_ready; cur_vld = i8t.out_valid; cur_vld_f = i8f.out_valid;
                cur_pt = 64'(i8t.product); cur_ot = i8t.trunc_ovf;
                cur_pf = 64'(i8f.product); cur_of = i8f.trunc_ovf;
            end
            1: begin
                cur_rdy = i4t.in_ready; cur_vld = i4t.out_valid; cur_vld_f = i4f.out_valid;
                cur_pt = 64'(i4t.product); cur_ot = i4t.trunc_ovf;
                cur_pf = 64'(i4f.product); cur_of = i4f.trunc_ovf;
            end
            2: begin
                cur_rdy = i16t.in_ready; cur_vld = i16t.out_valid; cur_vld_f = i16f.out_valid;
                cur_pt = 64'(i16t.product); cur_ot = i16t.trunc_ovf;
                cur_pf = 64'(i16f.product); cur_of = i16f.trunc_ovf;
            end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain sign/zero-extended 64-bit multiply, then masking.
    task automatic model(input int w, input bit s, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] pt, output bit ov, output logic [63:0] pf);
        logic [63:0] mask, av, bv, p, hs, smask;
        mask = (64'(1) << w) - 64'(1);
        av = 64'(a) & mask;
        bv = 64'(b) & mask;
        if (s && a[w-1]) av = av | ~mask;
        if (s && b[w-1]) bv = bv | ~mask;
        p  = av * bv;
        pf = p & ((64'(1) << (2 * w)) - 64'(1));
        pt = p & mask;
        smask = (64'(1) << (w + 1)) - 64'(1);
        hs = (p >> (w - 1)) & smask;
        ov = s ? !((hs == 64'(0)) || (hs == smask)) : ((pf >> w) != 64'(0));
    endtask

    // One transaction on the selected pair. hold = cycles out_ready stays low
    // in DONE; noisy = wiggle operands/in_valid while the unit is busy.
    task automatic run(input int w, input bit s, input logic [31:0] av, input logic [31:0] bv,
                       input logic [63:0] et, input bit eo, input logic [63:0] ef,
                       input int hold, input bit noisy);
        int k;
        logic [63:0] held;
        a_drv = av; b_drv = bv; sm = s; in_valid = 1'b1;
        out_ready = (hold == 0);
        k = 0;
        while (!cur_rdy && k < 100) begin @(posedge clk); #1; k++; end
        if (!cur_rdy) chk("accept_timeout", 64'(cur_rdy), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        while (!cur_vld && k < 200) begin
            if (noisy) begin
                in_valid = 1'($urandom_range(0, 1)); a_drv = $urandom; b_drv = $urandom; sm = ~sm;
            end
            @(posedge clk); #1; k++;
        end
        in_valid = 1'b0;
        chk("latency", 64'(k), 64'(w));
        chk("out_valid_full", 64'(cur_vld_f), 64'(1));
        chk("product_trunc", cur_pt, et);
        chk("ovf_trunc", 64'(cur_ot), 64'(eo));
        chk("product_full", cur_pf, ef);
        chk("ovf_full", 64'(cur_of), 64'(0));
        held = cur_pt;
        for (int i = 0; i < hold; i++) begin
            if (noisy) begin in_valid = 1'($urandom_range(0, 1)); a_drv = $urandom; b_drv = $urandom; end
            @(posedge clk); #1;
            chk("hold_product", cur_pt, held);
            chk("hold_in_ready", 64'(cur_rdy), 64'(0));
            chk("hold_out_valid", 64'(cur_vld), 64'(1));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("consume_out_valid", 64'(cur_vld), 64'(0));
        chk("consume_in_ready", 64'(cur_rdy), 64'(1));
    endtask

    typedef struct {
        bit          s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] et;
        bit          eo;
        logic [63:0] ef;
        int          hold;
        bit          noisy;
    } vec_t;

    initial begin
        vec_t tbl[11];
        logic [63:0] pt, pf;
        bit ov, s;
        logic [31:0] ra, rb;
        int vcnt;
        int acc_e[$];

        tbl[0]  = '{0, 32'hFF, 32'hFF, 64'h01, 1, 64'hFE01, 0, 0};
        tbl[1]  = '{0, 32'h0F, 32'h11, 64'hFF, 0, 64'h00FF, 5, 1};
        tbl[2]  = '{1, 32'hFF, 32'hFF, 64'h01, 0, 64'h0001, 0, 0};
        tbl[3]  = '{1, 32'h40, 32'h02, 64'h80, 1, 64'h0080, 0, 0};
        tbl[4]  = '{1, 32'h80, 32'h80, 64'h00, 1, 64'h4000, 2, 0};
        tbl[5]  = '{1, 32'hF0, 32'h04, 64'hC0, 0, 64'hFFC0, 0, 0};
        tbl[6]  = '{0, 32'h00, 32'hAB, 64'h00, 0, 64'h0000, 0, 0};
        tbl[7]  = '{1, 32'h7F, 32'h80, 64'h80, 1, 64'hC080, 0, 1};
        tbl[8]  = '{0, 32'h80, 32'h02, 64'h00, 1, 64'h0100, 0, 0};
        tbl[9]  = '{1, 32'h80, 32'h01, 64'h80, 0, 64'hFF80, 0, 0};
        tbl[10] = '{1, 32'h05, 32'hFD, 64'hF1, 0, 64'hFFF1, 0, 0};

        // Reset state
        grp = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(cur_rdy), 64'(1));
        chk("rst_out_valid", 64'(cur_vld), 64'(0));
        chk("rst_product", cur_pt, 64'(0));
        chk("rst_ovf", 64'(cur_ot), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed WIDTH=8 table
        foreach (tbl[i])
            run(8, tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].et, tbl[i].eo, tbl[i].ef, tbl[i].hold, tbl[i].noisy);

        // Async reset during the third BUSY cycle discards the operation
        a_drv = 32'd7; b_drv = 32'd9; sm = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(cur_vld), 64'(0));
        chk("midrst_product", cur_pt, 64'(0));
        chk("midrst_ovf", 64'(cur_ot), 64'(0));
        chk("midrst_in_ready", 64'(cur_rdy), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        vcnt = 0;
        for (int c = 0; c < 12; c++) begin @(posedge clk); #1; if (cur_vld) vcnt++; end
        chk("midrst_no_result", 64'(vcnt), 64'(0));
        run(8, 1'b0, 32'd3, 32'd5, 64'd15, 1'b0, 64'd15, 0, 0);

        // Back-to-back spacing with out_ready tied high, WIDTH=4
        grp = 1;
        out_ready = 1'b1; in_valid = 1'b1; sm = 1'b0; a_drv = 32'd3; b_drv = 32'd2;
        vcnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (cur_rdy) acc_e.push_back(c);
            if (cur_vld) vcnt++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("spacing_accepts", 64'(acc_e.size()), 64'(4));
        if (acc_e.size() >= 2) chk("spacing_cycles", 64'(acc_e[1] - acc_e[0]), 64'(6));
        chk("out_valid_cycles", 64'(vcnt), 64'(3));

        // Random sweeps against the reference model
        for (int g = 0; g < 3; g++) begin
            int w;
            grp = g;
            w = (g == 0) ? 8 : (g == 1) ? 4 : 16;
            for (int i = 0; i < 16; i++) begin
                s  = 1'($urandom_range(0, 1));
                ra = $urandom;
                rb = $urandom;
                if (i == 0) begin ra = 32'hFFFF_FFFF; rb = 32'hFFFF_FFFF; end
                if (i == 1) begin ra = 32'h1 << (w - 1); rb = 32'h1 << (w - 1); end
                model(w, s, ra, rb, pt, ov, pf);
                run(w, s, ra, rb, pt, ov, pf, (i % 5 == 4) ? 2 : 0, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
